// File: rtl/drop_pkg.sv
// Shared types and widths for the baggage-drop sequencer: FSM states,
// root iteration count and the Q8.8 time format.
package drop_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        ROOT,
        DECIDE
    } state_t;

    localparam int H_W     = 8;
    localparam int FRAC_W  = 8;
    localparam int TIME_W  = 16;
    localparam int RT_ITER = 12;

endpackage

// File: rtl/seq_sqrt.sv
// Iterative non-restoring square root engine that produces one root bit per cycle.
// The first iteration runs on the same edge that loads the radicand.
module seq_sqrt
    import drop_pkg::*;
#(
    parameter int ITER = RT_ITER
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                go,
    input  logic [2*ITER-1:0]   radicand,
    output logic [ITER-1:0]     root,
    output logic                ready
);

    localparam int REM_W = ITER + 2;
    localparam int CNT_W = $clog2(ITER + 1);

    logic [REM_W-1:0]  rem;
    logic [ITER-1:0]   q;
    logic [2*ITER-1:0] d;
    logic [CNT_W-1:0]  count;

    logic [REM_W-1:0]  cur_rem;
    logic [ITER-1:0]   cur_q;
    logic [2*ITER-1:0] cur_d;
    logic [REM_W-1:0]  shifted;
    logic [REM_W-1:0]  nxt_rem;
    logic [ITER-1:0]   nxt_q;
    logic [2*ITER-1:0] nxt_d;

    // A negative partial remainder is carried forward and corrected by adding
    // on the next step instead of being restored.
    always_comb begin
        cur_rem = go ? '0 : rem;
        cur_q   = go ? '0 : q;
        cur_d   = go ? radicand : d;
        shifted = REM_W'({cur_rem, cur_d[2*ITER-1 -: 2]});
        if (cur_rem[REM_W-1]) begin
            nxt_rem = shifted + {cur_q, 2'b11};
        end else begin
            nxt_rem = shifted - {cur_q, 2'b01};
        end
        nxt_q = {cur_q[ITER-2:0], ~nxt_rem[REM_W-1]};
        nxt_d = {cur_d[2*ITER-3:0], 2'b00};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem   <= '0;
            q     <= '0;
            d     <= '0;
            count <= '0;
            ready <= 1'b1;
        end else if (go) begin
            rem   <= nxt_rem;
            q     <= nxt_q;
            d     <= nxt_d;
            count <= CNT_W'(ITER - 1);
            ready <= (ITER == 1);
        end else if (count != '0) begin
            rem   <= nxt_rem;
            q     <= nxt_q;
            d     <= nxt_d;
            count <= count - CNT_W'(1);
            if (count == CNT_W'(1)) begin
                ready <= 1'b1;
            end
        end
    end

    assign root = q;

endmodule

// File: rtl/drop_sequencer.sv
// Timed controller that fuses the altitude sensors, takes the square root for
// the fall time and registers the drop decision with a done handshake.
module drop_sequencer
    import drop_pkg::*;
#(
    parameter int RT_ITER = drop_pkg::RT_ITER
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [H_W-1:0]    sensor1,
    input  logic [H_W-1:0]    sensor2,
    input  logic [H_W-1:0]    sensor3,
    input  logic [H_W-1:0]    sensor4,
    input  logic [TIME_W-1:0] t_lim,
    input  logic              drop_en,
    output logic              busy,
    output logic              done,
    output logic              fault,
    output logic [TIME_W-1:0] t_act,
    output logic              drop_activated
);

    localparam int RAD_W = 2 * RT_ITER;

    state_t              state;
    logic                fault_pend;
    logic                pair_a;
    logic                pair_b;
    logic                no_pair;
    logic [9:0]          sum_a;
    logic [9:0]          sum_b;
    logic [9:0]          sum_all;
    logic [H_W-1:0]      h;
    logic [RAD_W-1:0]    radicand;
    logic [RT_ITER-1:0]  root;
    logic                root_ready;
    logic                go;
    logic [TIME_W-1:0]   t_new;
    logic                t_ok;

    // Height fusion averages only the sensor pairs whose readings are both nonzero.
    always_comb begin
        sum_a   = 10'(sensor1) + 10'(sensor2);
        sum_b   = 10'(sensor3) + 10'(sensor4);
        sum_all = sum_a + sum_b + 10'd2;
        pair_a  = (sensor1 != '0) && (sensor2 != '0);
        pair_b  = (sensor3 != '0) && (sensor4 != '0);
        no_pair = !pair_a && !pair_b;
        if (pair_a && pair_b) begin
            h = H_W'(sum_all >> 2);
        end else if (pair_a) begin
            h = H_W'((sum_a + 10'd1) >> 1);
        end else begin
            h = H_W'((sum_b + 10'd1) >> 1);
        end
    end

    assign radicand = RAD_W'(h) << (2 * FRAC_W);
    assign go       = (state == SAMPLE) && !no_pair;
    assign t_new    = TIME_W'(root) >> 1;
    assign t_ok     = (t_new <= t_lim);

    seq_sqrt #(
        .ITER(RT_ITER)
    ) u_sqrt (
        .clk      (clk),
        .rst_n    (rst_n),
        .go       (go),
        .radicand (radicand),
        .root     (root),
        .ready    (root_ready)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            fault_pend     <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            fault          <= 1'b0;
            t_act          <= '0;
            drop_activated <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= SAMPLE;
                        busy  <= 1'b1;
                    end
                end
                SAMPLE: begin
                    fault_pend <= no_pair;
                    state      <= no_pair ? DECIDE : ROOT;
                end
                ROOT: begin
                    if (root_ready) begin
                        state <= DECIDE;
                    end
                end
                DECIDE: begin
                    fault <= fault_pend;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (fault_pend) begin
                        t_act          <= '0;
                        drop_activated <= 1'b0;
                    end else begin
                        t_act          <= t_new;
                        drop_activated <= drop_en & t_ok;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_drop_sequencer.sv
// Scoreboard bench for drop_sequencer: stimulus pushes expected results from a
// plain-arithmetic reference model, a monitor pops them on every done pulse.
module tb_drop_sequencer;

    typedef struct {
        int          cyc;
        bit          flt;
        logic [15:0] t;
        bit          drop;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  sensor1 = '0;
    logic [7:0]  sensor2 = '0;
    logic [7:0]  sensor3 = '0;
    logic [7:0]  sensor4 = '0;
    logic [15:0] t_lim = '0;
    logic        drop_en = 1'b0;
    logic        busy;
    logic        done;
    logic        fault;
    logic [15:0] t_act;
    logic        drop_activated;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    exp_t        sb[$];
    logic [17:0] last_out = '0;

    drop_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .sensor1        (sensor1),
        .sensor2        (sensor2),
        .sensor3        (sensor3),
        .sensor4        (sensor4),
        .t_lim          (t_lim),
        .drop_en        (drop_en),
        .busy           (busy),
        .done           (done),
        .fault          (fault),
        .t_act          (t_act),
        .drop_activated (drop_activated)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: fused height from the pair rules, then the largest r with r*r <= h*65536.
    function automatic exp_t model(input int a, input int b, input int c, input int d,
                                   input int lim, input bit en);
        exp_t   e;
        int     h;
        longint x;
        longint r;
        bit     pa;
        bit     pb;
        pa = (a != 0) && (b != 0);
        pb = (c != 0) && (d != 0);
        e.flt = !pa && !pb;
        if (pa && pb)  h = (a + b + c + d + 2) / 4;
        else if (pa)   h = (a + b + 1) / 2;
        else           h = (c + d + 1) / 2;
        x = longint'(h) * 65536;
        r = longint'($floor($sqrt(real'(x))));
        while (r * r > x) r--;
        while ((r + 1) * (r + 1) <= x) r++;
        if (e.flt) begin
            e.t    = 16'h0000;
            e.drop = 1'b0;
        end else begin
            e.t    = 16'(r / 2);
            e.drop = en && (int'(e.t) <= lim);
        end
        e.cyc = 0;
        return e;
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            n_checks++;
            $display("[TB] FAIL idle_timeout: busy still 1 after %0d cycles, expected 0", n);
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] a, input logic [7:0] b,
                                  input logic [7:0] c, input logic [7:0] d,
                                  input logic [15:0] lim, input bit en, input bit glitch,
                                  input bit directed, input logic [15:0] dt,
                                  input bit dd, input bit df);
        exp_t e;
        int   c0;
        wait_idle();
        sensor1 = a;
        sensor2 = b;
        sensor3 = c;
        sensor4 = d;
        t_lim   = lim;
        drop_en = en;
        start   = 1'b1;
        @(posedge clk);
        #1;
        c0    = cyc;
        start = 1'b0;
        check_output("busy_rise", 32'(busy), 32'd1);
        if (directed) begin
            e.flt  = df;
            e.t    = dt;
            e.drop = dd;
        end else begin
            e = model(int'(a), int'(b), int'(c), int'(d), int'(lim), en);
        end
        e.cyc = c0 + (e.flt ? 2 : 14);
        sb.push_back(e);
        if (glitch && !e.flt) begin
            repeat (3) @(negedge clk);
            start = 1'b1;
            while (cyc < c0 + 14) begin
                sensor1 = 8'($urandom_range(0, 255));
                sensor2 = 8'($urandom_range(0, 255));
                sensor3 = 8'($urandom_range(0, 255));
                sensor4 = 8'($urandom_range(0, 255));
                @(negedge clk);
            end
            start = 1'b0;
            @(negedge clk);
            check_output("restart_ignored", 32'(busy), 32'd0);
        end
        wait_idle();
    endtask

    // Monitor: pops on done, otherwise requires the result registers to hold.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            last_out = '0;
        end else if (done) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("[TB] FAIL unexpected_done: done=1 at cycle %0d, expected no done", cyc);
            end else begin
                e = sb.pop_front();
                check_output("done_cycle", 32'(cyc), 32'(e.cyc));
                check_output("fault", 32'(fault), 32'(e.flt));
                check_output("t_act", 32'(t_act), 32'(e.t));
                check_output("drop_activated", 32'(drop_activated), 32'(e.drop));
                last_out = {e.flt, e.drop, e.t};
            end
        end else begin
            check_output("outputs_held", 32'({fault, drop_activated, t_act}), 32'(last_out));
        end
    end

    initial begin
        int c0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_done", 32'(done), 32'd0);
        check_output("reset_fault", 32'(fault), 32'd0);
        check_output("reset_drop", 32'(drop_activated), 32'd0);
        check_output("reset_t_act", 32'(t_act), 32'd0);

        apply_stimulus(8'd64, 8'd64, 8'd64, 8'd64, 16'h0400, 1'b1, 1'b0, 1'b1, 16'h0400, 1'b1, 1'b0);
        apply_stimulus(8'd100, 8'd100, 8'd100, 8'd100, 16'h04FF, 1'b1, 1'b0, 1'b1, 16'h0500, 1'b0, 1'b0);
        apply_stimulus(8'd100, 8'd100, 8'd100, 8'd100, 16'h0500, 1'b1, 1'b0, 1'b1, 16'h0500, 1'b1, 1'b0);
        apply_stimulus(8'd50, 8'd51, 8'd0, 8'd90, 16'hFFFF, 1'b1, 1'b0, 1'b1, 16'h0392, 1'b1, 1'b0);
        apply_stimulus(8'd0, 8'd20, 8'd30, 8'd0, 16'hFFFF, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1);
        apply_stimulus(8'd64, 8'd64, 8'd64, 8'd64, 16'hFFFF, 1'b1, 1'b1, 1'b1, 16'h0400, 1'b1, 1'b0);

        // Reset in the middle of a measurement: no done, outputs cleared.
        sensor1 = 8'd100;
        sensor2 = 8'd100;
        sensor3 = 8'd100;
        sensor4 = 8'd100;
        start   = 1'b1;
        @(posedge clk);
        #1;
        c0    = cyc;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_output("midrst_busy", 32'(busy), 32'd0);
        check_output("midrst_done", 32'(done), 32'd0);
        check_output("midrst_fault", 32'(fault), 32'd0);
        check_output("midrst_drop", 32'(drop_activated), 32'd0);
        check_output("midrst_t_act", 32'(t_act), 32'd0);
        check_output("midrst_cycle", 32'(cyc - c0), 32'd6);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check_output("midrst_idle", 32'(busy), 32'd0);
        apply_stimulus(8'd64, 8'd64, 8'd64, 8'd64, 16'hFFFF, 1'b0, 1'b0, 1'b1, 16'h0400, 1'b0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            logic [7:0] s[4];
            for (int k = 0; k < 4; k++) begin
                s[k] = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            end
            apply_stimulus(s[0], s[1], s[2], s[3], 16'($urandom_range(0, 16'h0800)),
                           1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                           1'b0, 16'h0000, 1'b0, 1'b0);
        end

        repeat (5) @(negedge clk);
        check_output("scoreboard_drain", 32'(sb.size()), 32'd0);
        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
